// File: rtl/count_mon_pkg.sv
// Shared types, defaults and helpers for the count sequence monitor.
// Imported by count_seq_monitor and sat_counter.
package count_mon_pkg;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_SYNC_LEN   = 2;
  localparam int DEF_ERR_CNT_W  = 8;
  localparam int DEF_WRAP_CNT_W = 8;

  // good_run only needs to reach SYNC_LEN, which is at most 7.
  localparam int GR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  // Successor of a count value, modulo 2^width.
  function automatic logic [31:0] next_count(
    input logic [31:0] value,
    input int unsigned width
  );
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a level clear.
// Clear beats a same-cycle increment.
module sat_counter
  import count_mon_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  // Count up on inc, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a counter stream advances by +1 mod 2^WIDTH.
// Locks after a run of good steps; flags and counts breaks.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SYNC_LEN   = DEF_SYNC_LEN,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W,
  parameter int WRAP_CNT_W = DEF_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  count_valid,
  input  logic                  clr_stats,
  output logic                  locked,
  output logic                  seq_err,
  output logic                  err_sticky,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WIDTH-1:0]      last_count
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GR_W-1:0]  good_q, good_d;
  logic [GR_W-1:0]  good_inc;
  logic [WIDTH-1:0] expect_cnt;

  logic match;
  logic at_max;
  logic seq_err_d, wrap_d;
  logic seq_err_q, wrap_q, sticky_q;

  assign expect_cnt = WIDTH'(next_count(32'(prev_q), WIDTH));
  assign match      = (count_in == expect_cnt);
  assign at_max     = (prev_q == '1);
  assign good_inc   = good_q + 1'b1;

  // Next-state, compare and event decode; only valid samples move anything.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;
    if (count_valid) begin
      prev_d = count_in;
      unique case (state_q)
        IDLE: begin
          good_d  = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == GR_W'(SYNC_LEN)) begin
              state_d = LOCK;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCK: begin
          if (match) begin
            wrap_d = at_max;
          end else begin
            seq_err_d = 1'b1;
            good_d    = '0;
            state_d   = ACQ;
          end
        end
        default: begin
          good_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, history and one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      good_q    <= '0;
      seq_err_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      seq_err_q <= seq_err_d;
      wrap_q    <= wrap_d;
    end
  end

  // Sticky error flag; a clear wins over a same-cycle error.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (clr_stats) begin
      sticky_q <= 1'b0;
    end else if (seq_err_d) begin
      sticky_q <= 1'b1;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (seq_err_d),
    .q     (err_cnt)
  );

  sat_counter #(
    .W (WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (wrap_d),
    .q     (wrap_cnt)
  );

  assign locked     = (state_q == LOCK);
  assign seq_err    = seq_err_q;
  assign wrap_pulse = wrap_q;
  assign err_sticky = sticky_q;
  assign last_count = prev_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: two instances (8-bit and
// 2-bit error counter) checked every cycle against a behavioural model.
module tb_count_seq_monitor;

  localparam int W    = 3;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] count_in = '0;
  logic         count_valid = 1'b0;
  logic         clr_stats = 1'b0;

  logic         a_locked, a_seq_err, a_sticky, a_wrap_pulse;
  logic [7:0]   a_wrap_cnt, a_err_cnt;
  logic [W-1:0] a_last;

  logic         b_locked, b_seq_err, b_sticky, b_wrap_pulse;
  logic [7:0]   b_wrap_cnt;
  logic [1:0]   b_err_cnt;
  logic [W-1:0] b_last;

  count_seq_monitor u_a (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .clr_stats   (clr_stats),
    .locked      (a_locked),
    .seq_err     (a_seq_err),
    .err_sticky  (a_sticky),
    .wrap_pulse  (a_wrap_pulse),
    .wrap_cnt    (a_wrap_cnt),
    .err_cnt     (a_err_cnt),
    .last_count  (a_last)
  );

  count_seq_monitor #(
    .ERR_CNT_W (2)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .clr_stats   (clr_stats),
    .locked      (b_locked),
    .seq_err     (b_seq_err),
    .err_sticky  (b_sticky),
    .wrap_pulse  (b_wrap_pulse),
    .wrap_cnt    (b_wrap_cnt),
    .err_cnt     (b_err_cnt),
    .last_count  (b_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = not started, 1 = searching, 2 = locked.
  int mode = 0, prev = 0, run = 0;
  int errs = 0, wraps = 0;
  bit m_seq = 0, m_wp = 0, m_sticky = 0;
  bit started = 0;
  bit is_next;

  function automatic int sat(input int v, input int bits);
    int top;
    top = (1 << bits) - 1;
    return (v > top) ? top : v;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      mode = 0; prev = 0; run = 0;
      errs = 0; wraps = 0;
      m_seq = 0; m_wp = 0; m_sticky = 0;
    end else begin
      m_seq = 0;
      m_wp  = 0;
      if (count_valid) begin
        is_next = (int'(count_in) == (prev + 1) % (1 << W));
        if (mode == 0) begin
          mode = 1;
          run  = 0;
        end else if (mode == 1) begin
          if (is_next) begin
            run++;
            if (run == SYNC) mode = 2;
          end else begin
            run = 0;
          end
        end else begin
          if (is_next) begin
            if (prev == (1 << W) - 1) begin
              m_wp = 1;
              wraps++;
            end
          end else begin
            m_seq = 1;
            errs++;
            m_sticky = 1;
            mode = 1;
            run  = 0;
          end
        end
        prev = int'(count_in);
      end
      if (clr_stats) begin
        errs = 0; wraps = 0; m_sticky = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_locked",   int'(a_locked),     int'(mode == 2));
      chk("a_seq_err",  int'(a_seq_err),    int'(m_seq));
      chk("a_sticky",   int'(a_sticky),     int'(m_sticky));
      chk("a_wrap_p",   int'(a_wrap_pulse), int'(m_wp));
      chk("a_wrap_cnt", int'(a_wrap_cnt),   sat(wraps, 8));
      chk("a_err_cnt",  int'(a_err_cnt),    sat(errs, 8));
      chk("a_last",     int'(a_last),       prev);
      chk("b_locked",   int'(b_locked),     int'(mode == 2));
      chk("b_seq_err",  int'(b_seq_err),    int'(m_seq));
      chk("b_sticky",   int'(b_sticky),     int'(m_sticky));
      chk("b_wrap_p",   int'(b_wrap_pulse), int'(m_wp));
      chk("b_wrap_cnt", int'(b_wrap_cnt),   sat(wraps, 8));
      chk("b_err_cnt",  int'(b_err_cnt),    sat(errs, 2));
      chk("b_last",     int'(b_last),       prev);
    end
  end

  task automatic step(input bit v, input int c);
    count_valid = v;
    count_in    = W'(c);
    @(posedge clk);
    #1;
  endtask

  int p;

  initial begin
    // 1: reset, free-running stream, lock and three wraps
    reset = 1'b1;
    repeat (5) step(1'b0, 0);
    chk("rst_locked", int'(a_locked), 0);
    chk("rst_last",   int'(a_last), 0);
    reset = 1'b0;
    for (int i = 0; i <= 27; i++) begin
      step(1'b1, i % 8);
      if (i == 1) chk("t1_nolock", int'(a_locked), 0);
      if (i == 2) chk("t1_lock", int'(a_locked), 1);
      if (i == 8) begin
        chk("t1_wp", int'(a_wrap_pulse), 1);
        chk("t1_wc1", int'(a_wrap_cnt), 1);
      end
      if (i == 9) chk("t1_wp_off", int'(a_wrap_pulse), 0);
    end
    chk("t1_wc3", int'(a_wrap_cnt), 3);
    chk("t1_ec0", int'(a_err_cnt), 0);

    // 2: skip a value while locked, then relock
    step(1'b1, 5);
    chk("t2_seq", int'(a_seq_err), 1);
    chk("t2_ec", int'(a_err_cnt), 1);
    chk("t2_sticky", int'(a_sticky), 1);
    chk("t2_unlock", int'(a_locked), 0);
    step(1'b1, 6);
    chk("t2_seq_off", int'(a_seq_err), 0);
    chk("t2_acq", int'(a_locked), 0);
    step(1'b1, 7);
    chk("t2_relock", int'(a_locked), 1);

    // 3: valid gap with junk on count_in
    for (int i = 0; i < 4; i++) begin
      step(1'b0, int'($urandom_range(0, 7)));
      chk("t3_hold", int'(a_last), 7);
      chk("t3_lock", int'(a_locked), 1);
    end
    step(1'b1, 0);
    chk("t3_noerr", int'(a_seq_err), 0);
    chk("t3_wp", int'(a_wrap_pulse), 1);

    // 4: five more errors with relocks, narrow counter saturates
    p = 0;
    for (int e = 0; e < 5; e++) begin
      step(1'b1, (p + 2) % 8);
      step(1'b1, (p + 3) % 8);
      step(1'b1, (p + 4) % 8);
      p = (p + 4) % 8;
    end
    chk("t4_b_sat", int'(b_err_cnt), 3);
    chk("t4_a_ec", int'(a_err_cnt), 6);
    chk("t4_sticky", int'(b_sticky), 1);
    clr_stats = 1'b1;
    step(1'b1, (p + 1) % 8);
    clr_stats = 1'b0;
    chk("t4_b_clr", int'(b_err_cnt), 0);
    chk("t4_sticky_clr", int'(b_sticky), 0);

    // 5: clear on the same cycle as a wrap
    for (int i = 1; i <= 18; i++) step(1'b1, (5 + i) % 8);
    chk("t5_wc2", int'(a_wrap_cnt), 2);
    clr_stats = 1'b1;
    step(1'b1, 0);
    clr_stats = 1'b0;
    chk("t5_wp", int'(a_wrap_pulse), 1);
    chk("t5_wc0", int'(a_wrap_cnt), 0);

    // 6: reset mid-lock, reacquire on 5,6,7
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 3);
    step(1'b1, 4);
    chk("t6_pre", int'(a_locked), 1);
    reset = 1'b1;
    step(1'b1, 4);
    reset = 1'b0;
    chk("t6_rst_lock", int'(a_locked), 0);
    chk("t6_rst_last", int'(a_last), 0);
    chk("t6_rst_sticky", int'(a_sticky), 0);
    step(1'b1, 5);
    chk("t6_idle", int'(a_locked), 0);
    step(1'b1, 6);
    chk("t6_acq", int'(a_locked), 0);
    step(1'b1, 7);
    chk("t6_relock", int'(a_locked), 1);
    step(1'b1, 0);
    chk("t6_wp", int'(a_wrap_pulse), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
